// File: rtl/jk_bank_ctrl.sv
// Sequences a JK flop bank: per-cycle jk codes from a latched command and live q feedback.
// One RUN cycle per (len+1), then a one-cycle DONE; cmd_ready only in IDLE, no command queuing.
module jk_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [3:0]         cmd_len,
    input  logic               abort,
    input  logic [WIDTH-1:0]   q_fb,
    output logic [2*WIDTH-1:0] jk_bus,
    output logic               busy,
    output logic               done,
    output logic               wrapped
);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_UP     = 3'b100;
    localparam logic [2:0] OP_DOWN   = 3'b101;
    localparam logic [2:0] OP_INVERT = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic [3:0]       cnt;
    logic             ones_below;
    logic             zeros_below;
    logic             wrap_hit;

    assign wrap_hit = ((op == OP_UP) && (&q_fb)) || ((op == OP_DOWN) && !(|q_fb));

    // Counting ops toggle flop i only when every lower flop is at the carry/borrow value.
    always_comb begin
        jk_bus      = '0;
        ones_below  = 1'b1;
        zeros_below = 1'b1;
        if (state == RUN && !abort) begin
            for (int i = 0; i < WIDTH; i++) begin
                case (op)
                    OP_CLEAR:  jk_bus[2*i +: 2] = 2'b01;
                    OP_SET:    jk_bus[2*i +: 2] = 2'b10;
                    OP_LOAD:   jk_bus[2*i +: 2] = {data[i], ~data[i]};
                    OP_UP:     jk_bus[2*i +: 2] = ones_below  ? 2'b11 : 2'b00;
                    OP_DOWN:   jk_bus[2*i +: 2] = zeros_below ? 2'b11 : 2'b00;
                    OP_INVERT: jk_bus[2*i +: 2] = 2'b11;
                    default:   jk_bus[2*i +: 2] = 2'b00;
                endcase
                ones_below  = ones_below  & q_fb[i];
                zeros_below = zeros_below & ~q_fb[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_HOLD;
            data      <= '0;
            cnt       <= '0;
            wrapped   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op        <= cmd_op;
                        data      <= cmd_data;
                        cnt       <= cmd_len;
                        wrapped   <= 1'b0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!abort && wrap_hit)
                        wrapped <= 1'b1;
                    if (abort || cnt == 4'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl driving a behavioural 4-flop JK bank from jk_bus.
module tb_jk_bank_ctrl;

    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_UP     = 3'b100;
    localparam logic [2:0] OP_DOWN   = 3'b101;
    localparam logic [2:0] OP_INVERT = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_len;
    logic       abort;
    logic [3:0] q;
    logic [7:0] jk_bus;
    logic       busy;
    logic       done;
    logic       wrapped;
    logic       bank_load;
    logic [3:0] bank_init;

    int n_chk = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    jk_bank_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .q_fb      (q),
        .jk_bus    (jk_bus),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped)
    );

    // Behavioural JK bank; not reset by rst_n, preloadable by the bench.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bank_load)
                q[i] <= bank_init[i];
            else
                case (jk_bus[2*i +: 2])
                    2'b01:   q[i] <= 1'b0;
                    2'b10:   q[i] <= 1'b1;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_q(input logic [3:0] v);
        bank_init = v;
        bank_load = 1'b1;
        tick();
        bank_load = 1'b0;
    endtask

    // Returns at the falling edge inside the first RUN cycle.
    task automatic issue(input logic [2:0] op, input logic [3:0] dat, input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = dat;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0;
        abort = 1'b0; bank_load = 1'b1; bank_init = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_jk", jk_bus, 0);
        rst_n = 1'b1;
        bank_load = 1'b0;
        tick();

        // UP over 16 cycles from 0000 wraps back to 0000
        set_q(4'h0);
        issue(OP_UP, 4'h0, 4'd15);
        chk("up_ready", cmd_ready, 0);
        chk("up_busy", busy, 1);
        chk("up_jk0", jk_bus, 8'h03);
        n = 0;
        while (!done && n < 40) begin
            chk("up_q", q, n[3:0]);
            tick();
            n++;
        end
        chk("up_cycles", n, 16);
        chk("up_q_end", q, 4'h0);
        chk("up_wrap", wrapped, 1);
        chk("up_done_jk", jk_bus, 0);
        chk("up_done_busy", busy, 1);
        tick();
        chk("up_done_once", done, 0);
        chk("up_idle_ready", cmd_ready, 1);
        chk("up_wrap_hold", wrapped, 1);

        // LOAD 1010 in one cycle
        issue(OP_LOAD, 4'b1010, 4'd0);
        chk("load_jk", jk_bus, 8'h99);
        chk("load_wrap_clr", wrapped, 0);
        tick();
        chk("load_done", done, 1);
        chk("load_q", q, 4'hA);
        tick();

        // DOWN from 0000: 1111, 1110, 1101
        set_q(4'h0);
        issue(OP_DOWN, 4'h0, 4'd2);
        chk("down_jk0", jk_bus, 8'hFF);
        tick();
        chk("down_q1", q, 4'hF);
        chk("down_wrap", wrapped, 1);
        chk("down_jk1", jk_bus, 8'h03);
        tick();
        chk("down_q2", q, 4'hE);
        chk("down_jk2", jk_bus, 8'h0F);
        tick();
        chk("down_q3", q, 4'hD);
        chk("down_done", done, 1);
        tick();

        // INVERT len 7, aborted in its third cycle
        set_q(4'h5);
        issue(OP_INVERT, 4'h0, 4'd7);
        chk("inv_jk", jk_bus, 8'hFF);
        chk("inv_wrap_clr", wrapped, 0);
        tick();
        chk("inv_q1", q, 4'hA);
        tick();
        chk("inv_q2", q, 4'h5);
        abort = 1'b1;
        #1;
        chk("inv_abort_jk", jk_bus, 0);
        tick();
        abort = 1'b0;
        chk("inv_abort_done", done, 1);
        chk("inv_q_end", q, 4'h5);
        tick();
        chk("inv_idle", busy, 0);

        // Reserved opcode runs as HOLD for len+1 cycles
        set_q(4'h6);
        issue(OP_RSVD, 4'hF, 4'd2);
        chk("rsvd_jk", jk_bus, 0);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("rsvd_cycles", n, 3);
        chk("rsvd_q", q, 4'h6);
        tick();

        // Reset in the middle of an UP run
        set_q(4'h0);
        issue(OP_UP, 4'h0, 4'd15);
        repeat (3) tick();
        chk("rst_mid_q", q, 4'h3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_jk", jk_bus, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        tick();
        chk("rst_mid_done", done, 0);
        chk("rst_mid_hold", q, 4'h3);
        rst_n = 1'b1;
        issue(OP_CLEAR, 4'h0, 4'd0);
        chk("clr_jk", jk_bus, 8'h55);
        tick();
        chk("clr_done", done, 1);
        chk("clr_q", q, 4'h0);
        tick();

        // cmd_valid held: SET then CLEAR accepted only after DONE
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_len = 4'd1;
        tick();
        cmd_op = OP_CLEAR; cmd_len = 4'd0;
        chk("b2b_run_ready", cmd_ready, 0);
        chk("b2b_set_jk", jk_bus, 8'hAA);
        tick();
        chk("b2b_set_jk2", jk_bus, 8'hAA);
        tick();
        chk("b2b_done", done, 1);
        chk("b2b_done_ready", cmd_ready, 0);
        chk("b2b_set_q", q, 4'hF);
        tick();
        chk("b2b_idle_ready", cmd_ready, 1);
        chk("b2b_idle_busy", busy, 0);
        tick();
        chk("b2b_clr_jk", jk_bus, 8'h55);
        cmd_valid = 1'b0;
        tick();
        chk("b2b_clr_done", done, 1);
        chk("b2b_clr_q", q, 4'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/jk_bank_ctrl.md
JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Sequences a bank of WIDTH JK flip-flops (2-bit jk code per flop: bit1 = J, bit0 = K) by driving per-cycle jk codes from a command handshake and the bank's q feedback.

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, number of JK flip-flops in the controlled bank (legal range 2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cmd_valid  input  1  command request.
REQ-005 SHALL have port: cmd_ready  output  1  controller can accept a command.
REQ-006 SHALL have port: cmd_op  input  3  opcode: 000 HOLD, 001 CLEAR, 010 SET, 011 LOAD, 100 UP, 101 DOWN, 110 INVERT, 111 reserved.
REQ-007 SHALL have port: cmd_data  input  WIDTH  LOAD value.
REQ-008 SHALL have port: cmd_len  input  4  number of RUN cycles minus one (0 means 1 cycle, 15 means 16 cycles).
REQ-009 SHALL have port: abort  input  1  terminate the current command early.
REQ-010 SHALL have port: q_fb  input  WIDTH  current q outputs of the bank.
REQ-011 SHALL have port: jk_bus  output  2*WIDTH  jk code for flop i on jk_bus[2i+1:2i].
REQ-012 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: wrapped  output  1  sticky flag: an UP/DOWN step wrapped during the current or last command.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on a rising edge with cmd_valid && cmd_ready.
REQ-017 On acceptance, SHALL latch op, data and len, clear wrapped, load the remaining-cycle counter with cmd_len, and go IDLE -> RUN.
REQ-018 In RUN, jk_bus SHALL be combinational from the latched op, latched data and live q_fb; the bank updates on the edge that ends each RUN cycle.
REQ-019 Per-flop codes in RUN SHALL be: HOLD and reserved 00; CLEAR 01; SET 10; LOAD J = data[i], K = ~data[i]; INVERT 11.
REQ-020 For UP, flop i SHALL get 11 if q_fb[i-1:0] are all 1 (flop 0 always 11), else 00.
REQ-021 For DOWN, flop i SHALL get 11 if q_fb[i-1:0] are all 0 (flop 0 always 11), else 00.
REQ-022 On each RUN-cycle edge, counter = 0 SHALL give RUN -> DONE; otherwise the counter decrements.
REQ-023 With abort = 1 in a RUN cycle, jk_bus SHALL be all 00 for that cycle and the next edge SHALL give RUN -> DONE regardless of the counter.
REQ-024 DONE SHALL last exactly one cycle with done = 1 and jk_bus = 00, then go to IDLE; done SHALL be 0 in every other state.
REQ-025 Outside RUN, jk_bus SHALL be all 00.
REQ-026 Wrapped SHALL be set on a RUN-cycle edge when UP sees q_fb all 1s, or DOWN sees q_fb all 0s, and that cycle is not aborted; it holds until the next acceptance.
REQ-027 cmd_valid in RUN or DONE SHALL be ignored (no queuing).
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 Reserved opcode 111 SHALL run its full length as HOLD and then pulse done.

Reset
REQ-030 While rst_n = 0, asynchronously: state IDLE, counter 0, latched op/data 0, done 0, wrapped 0, busy 0, jk_bus all 00, cmd_ready 1.
REQ-031 Reset asserted mid-RUN SHALL immediately force jk_bus to 00 with no done pulse; the first acceptance is possible on the first rising edge after rst_n rises.

Verification
REQ-032 Scenario: WIDTH = 4, q_fb = 0000, UP with len = 15 -> 16 RUN cycles, bank counts 0001..1111 then 0000, wrapped = 1, done pulses once at cycle 17.
REQ-033 Scenario: LOAD data = 1010, len = 0 -> one RUN cycle with jk_bus = 10_01_10_01, bank q = 1010, then done.
REQ-034 Scenario: q_fb = 0000, DOWN with len = 2 -> bank goes 1111, 1110, 1101; wrapped = 1 after the first step.
REQ-035 Scenario: INVERT with len = 7, abort raised in RUN cycle 3 -> jk_bus = 00 in cycle 3, DONE next, 2 toggles total, q back to its start value.
REQ-036 Scenario: rst_n low during RUN of UP -> jk_bus = 00 and busy = 0 immediately, no done, cmd_ready = 1; a CLEAR issued after release gives q = 0000.
REQ-037 Scenario: cmd_valid held high with back-to-back SET and CLEAR -> the second command is accepted only after the done cycle (cmd_ready low in RUN and DONE).
